// File: rtl/timer_switch_ctrl.sv
// timer_switch_ctrl: staircase-light timer with retrigger, cancel and a blinking warn tail.
module timer_switch_ctrl #(
    parameter int CLK_PER_SEC  = 50_000_000,
    parameter int ON_SECONDS   = 30,
    parameter int WARN_SECONDS = 5,
    localparam int RW = $clog2(ON_SECONDS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic          cancel,
    output logic          light,
    output logic          warn,
    output logic [RW-1:0] remaining
);
    localparam int PW = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0] P_MAX  = PW'(CLK_PER_SEC - 1);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_PER_SEC / 2);
    localparam logic [RW-1:0] R_ON   = RW'(ON_SECONDS);
    localparam logic [RW-1:0] R_WARN = RW'(WARN_SECONDS);

    if (CLK_PER_SEC < 2 || CLK_PER_SEC % 2 != 0) begin : g_bad_clk
        $error("CLK_PER_SEC must be >= 2 and even");
    end
    if (ON_SECONDS < 1) begin : g_bad_on
        $error("ON_SECONDS must be >= 1");
    end
    if (WARN_SECONDS < 0 || WARN_SECONDS >= ON_SECONDS) begin : g_bad_warn
        $error("WARN_SECONDS must be in 0..ON_SECONDS-1");
    end

    typedef enum logic [1:0] {OFF, ON, WARN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] rem_q, rem_d, rem_dec;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OFF;
            presc_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            rem_q   <= rem_d;
        end
    end

    // cancel beats tick; a second boundary moves the countdown on by one second
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        rem_d   = rem_q;
        rem_dec = rem_q - RW'(1);
        if (cancel) begin
            state_d = OFF;
            presc_d = '0;
            rem_d   = '0;
        end else if (tick) begin
            state_d = ON;
            presc_d = '0;
            rem_d   = R_ON;
        end else if (state_q != OFF) begin
            if (presc_q != P_MAX) begin
                presc_d = presc_q + PW'(1);
            end else begin
                presc_d = '0;
                rem_d   = rem_dec;
                state_d = (rem_dec == '0) ? OFF
                        : (WARN_SECONDS > 0 && rem_dec == R_WARN) ? WARN : state_q;
            end
        end
    end

    assign light     = (state_q == ON) || (state_q == WARN && presc_q < P_HALF);
    assign warn      = (state_q == WARN);
    assign remaining = rem_q;
endmodule

// File: tb/tb_timer_switch_ctrl.sv
// tb_timer_switch_ctrl: scoreboard bench for a warn and a no-warn configuration driven in parallel.
module tb_timer_switch_ctrl;
    localparam int CPS = 4;

    typedef struct packed {
        logic       light;
        logic       warn;
        logic [1:0] rem;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       cancel = 1'b0;
    logic       light0, warn0, light1, warn1;
    logic [1:0] rem0, rem1;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    exp_t q0[$];
    exp_t q1[$];

    int ons[2]  = '{3, 2};
    int wrns[2] = '{1, 0};
    bit busy[2] = '{0, 0};
    int t[2]    = '{0, 0};

    timer_switch_ctrl #(.CLK_PER_SEC(CPS), .ON_SECONDS(3), .WARN_SECONDS(1)) dut0 (
        .clock(clock), .reset(reset), .tick(tick), .cancel(cancel),
        .light(light0), .warn(warn0), .remaining(rem0)
    );

    timer_switch_ctrl #(.CLK_PER_SEC(CPS), .ON_SECONDS(2), .WARN_SECONDS(0)) dut1 (
        .clock(clock), .reset(reset), .tick(tick), .cancel(cancel),
        .light(light1), .warn(warn1), .remaining(rem1)
    );

    always #5 clock = ~clock;

    // t counts cycles since the tick edge; everything else follows from seconds arithmetic
    function automatic exp_t model(int i);
        exp_t e;
        bit   w;
        e = '0;
        if (busy[i]) begin
            w       = wrns[i] > 0 && t[i] >= (ons[i] - wrns[i]) * CPS;
            e.warn  = w;
            e.light = !w || (t[i] % CPS) < CPS / 2;
            e.rem   = 2'(ons[i] - t[i] / CPS);
        end
        return e;
    endfunction

    task automatic step(bit tk, bit cn, bit rs);
        @(negedge clock);
        #1;
        tick   = tk;
        cancel = cn;
        reset  = rs;
        for (int i = 0; i < 2; i++) begin
            if (rs || cn) begin
                busy[i] = 0;
            end else if (tk) begin
                busy[i] = 1;
                t[i]    = 0;
            end else if (busy[i]) begin
                t[i]++;
                if (t[i] >= ons[i] * CPS) busy[i] = 0;
            end
        end
        q0.push_back(model(0));
        q1.push_back(model(1));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic chk(string name, exp_t act, exp_t e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got light=%0b warn=%0b rem=%0d, want light=%0b warn=%0b rem=%0d",
                     name, cycle, act.light, act.warn, act.rem, e.light, e.warn, e.rem);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        cycle++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("dut0_outputs", {light0, warn0, rem0}, e);
            if (e.rem == 2'd0) begin
                checks++;
                if (dut0.presc_q !== '0) begin
                    errors++;
                    $display("FAIL dut0_presc_off cycle %0d: got %0d, want 0", cycle, dut0.presc_q);
                end
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("dut1_outputs", {light1, warn1, rem1}, e);
        end
    end

    initial begin
        step(0, 0, 1);
        step(0, 0, 1);
        idle(3);
        // basic period, then idle past the end
        step(1, 0, 0);
        idle(15);
        // retrigger inside the warn tail
        step(1, 0, 0);
        idle(9);
        step(1, 0, 0);
        idle(15);
        // cancel and tick on the same edge
        step(1, 0, 0);
        idle(4);
        step(1, 1, 0);
        idle(6);
        // reset mid-period with a simultaneous tick, then a clean period
        step(1, 0, 0);
        idle(5);
        step(1, 0, 1);
        idle(2);
        step(1, 0, 0);
        idle(15);
        // long idle
        idle(100);
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
        end
        idle(15);
        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_switch_ctrl.md
Name: timer_switch_ctrl

Overview:
- Staircase-light controller. It consumes the one-cycle button pulse produced by the edge-detect stage and drives the lamp.
- Each pulse turns the lamp on for ON_SECONDS. During the last WARN_SECONDS the lamp blinks to warn that it is about to switch off.
- A new pulse while lit retriggers the full period. A cancel input forces the lamp off.
- Sits directly downstream of the single-shot edge detector in the timer-switch example.

Parameters:
- CLK_PER_SEC, 50_000_000: clock cycles per second. Must be >= 2 and even.
- ON_SECONDS, 30: total lit period in seconds. Must be >= 1.
- WARN_SECONDS, 5: length of the blinking tail in seconds. Must be < ON_SECONDS. 0 means no warn phase.
- Any parameter violation is an elaboration-time error.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- tick  input  1  one-cycle start/retrigger pulse from the edge detector.
- cancel  input  1  level; forces OFF.
- light  output  1  lamp drive.
- warn  output  1  high while in the WARN state.
- remaining  output  $clog2(ON_SECONDS+1)  whole seconds left; 0 when OFF.

Behaviour:
- Registers:
  - state: OFF, ON, WARN.
  - presc: 0..CLK_PER_SEC-1.
  - remaining.
- One clock, synchronous active-high reset. All updates happen on the rising edge of clock.
- Reset (synchronous, sampled on a clock edge) sets state=OFF, presc=0, remaining=0. Outputs therefore become light=0, warn=0, remaining=0. Reset has priority over all other inputs, including mid-period.
- Outputs are decoded from registers only. There is no combinational path from tick or cancel to any output.
  - light = (state==ON) | (state==WARN & presc < CLK_PER_SEC/2).
  - warn = (state==WARN).
- Priority per edge: reset > cancel > tick > countdown.
- cancel=1: state=OFF, presc=0, remaining=0. This applies even when tick=1 in the same cycle.
- tick=1 in any state: state=ON, presc=0, remaining=ON_SECONDS. This covers both start and retrigger.
  - Latency: tick sampled at edge k, light=1 from cycle k+1.
- Countdown (state ON or WARN, no tick, no cancel):
  - If presc < CLK_PER_SEC-1: presc++.
  - Otherwise presc=0 and remaining--.
    - If the new remaining==WARN_SECONDS and WARN_SECONDS>0: state=WARN.
    - If the new remaining==0: state=OFF.
- State ON lasts (ON_SECONDS-WARN_SECONDS)*CLK_PER_SEC cycles. State WARN lasts WARN_SECONDS*CLK_PER_SEC cycles. The total lit-or-blinking period is exactly ON_SECONDS*CLK_PER_SEC cycles after the tick edge.
- WARN blink: lamp on for the first half of each second and off for the second half, phase-locked to presc.
- In OFF with no tick: all registers hold; presc stays 0.
- No wrap-around: remaining never decrements below 0; presc wraps CLK_PER_SEC-1 -> 0 only while counting.

Test Plan:
All scenarios use CLK_PER_SEC=4, ON_SECONDS=3, WARN_SECONDS=1, and tick pulsed at edge k.
- Basic period:
  - Cycles k+1..k+8: light=1, warn=0; remaining=3 for k+1..k+4, then 2 for k+5..k+8.
  - Cycles k+9..k+12: warn=1, remaining=1, light=1,1,0,0.
  - Cycle k+13: light=0, warn=0, remaining=0.
- Retrigger in WARN: second tick at edge k+10 -> cycle k+11 shows state ON, remaining=3, light=1. The lamp goes off at cycle k+23.
- Cancel/tick collision: cancel=1 and tick=1 both at edge k+5 -> cycle k+6: light=0, remaining=0, warn=0. The block stays OFF until the next tick.
- Reset mid-operation: reset=1 at edge k+6 -> cycle k+7: all outputs 0. A tick at the edge where reset is asserted is ignored. A tick after reset deasserts gives a normal 12-cycle period.
- No-warn configuration: WARN_SECONDS=0, ON_SECONDS=2 -> light=1 for exactly 8 cycles, warn never asserts, remaining goes 2,1 then 0.
- Idle: with no tick for 100 cycles after reset, light=0 and remaining=0 throughout; presc stays 0 (checked via assertion).
